// File: rtl/mod_counter_pkg.sv
// Shared types and constants for the modular up/down counter.
package mod_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'd0,
    MODE_SATURATE = 2'd1,
    MODE_ONESHOT  = 2'd2
  } mode_e;

  // Encoding 3 is not a named mode; it behaves exactly like WRAP.
  localparam logic [1:0] MODE_RESERVED = 2'd3;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count and crossing detection for mod_counter.
module mod_counter_next
  import mod_counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  q_i,
  input  logic              up_down_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [WIDTH-1:0]  max_val_i,
  input  logic [1:0]        mode_i,
  output logic [WIDTH-1:0]  next_q_o,
  output logic              ovf_cross_o,
  output logic              unf_cross_o
);

  logic [WIDTH:0] q_x;
  logic [WIDTH:0] max_x;
  logic [WIDTH:0] step_x;
  logic [WIDTH:0] s_x;
  logic [WIDTH:0] lim_x;
  logic [WIDTH:0] sum_x;
  logic [WIDTH:0] diff_x;
  logic [WIDTH:0] wrap_up_x;
  logic [WIDTH:0] wrap_dn_x;
  logic           wrap_mode;

  // Everything is evaluated one bit wider so q+s and q+max+1 never overflow.
  always_comb begin
    q_x       = {1'b0, q_i};
    max_x     = {1'b0, max_val_i};
    step_x    = {{(WIDTH + 1 - STEP_W){1'b0}}, step_i};
    s_x       = (step_x < max_x) ? step_x : max_x;
    lim_x     = max_x + 1'b1;
    sum_x     = q_x + s_x;
    diff_x    = q_x - s_x;
    wrap_up_x = sum_x - lim_x;
    wrap_dn_x = q_x + lim_x - s_x;
    wrap_mode = (mode_i == MODE_WRAP) || (mode_i == MODE_RESERVED);
  end

  always_comb begin
    next_q_o    = q_i;
    ovf_cross_o = 1'b0;
    unf_cross_o = 1'b0;
    if (q_x > max_x) begin
      // Ceiling was lowered under the current count: snap down silently.
      next_q_o = max_val_i;
    end else if (s_x != '0) begin
      if (up_down_i) begin
        if (sum_x <= max_x) begin
          next_q_o = sum_x[WIDTH-1:0];
        end else begin
          ovf_cross_o = 1'b1;
          next_q_o    = wrap_mode ? wrap_up_x[WIDTH-1:0] : max_val_i;
        end
      end else begin
        if (q_x >= s_x) begin
          next_q_o = diff_x[WIDTH-1:0];
        end else begin
          unf_cross_o = 1'b1;
          next_q_o    = wrap_mode ? wrap_dn_x[WIDTH-1:0] : '0;
        end
      end
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Modular up/down counter with wrap/saturate/oneshot modes and sticky flags.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  max_val,
  input  logic [1:0]        mode,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clear_flags,
  output logic [WIDTH-1:0]  q,
  output logic              tc,
  output logic              ovf,
  output logic              unf,
  output logic              done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH-1:0] nxt_q;
  logic             ovf_cross;
  logic             unf_cross;
  logic [WIDTH-1:0] load_clamp;
  logic             count_en;

  mod_counter_next #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_next (
    .q_i         (q_q),
    .up_down_i   (up_down),
    .step_i      (step),
    .max_val_i   (max_val),
    .mode_i      (mode),
    .next_q_o    (nxt_q),
    .ovf_cross_o (ovf_cross),
    .unf_cross_o (unf_cross)
  );

  assign load_clamp = (load_val > max_val) ? max_val : load_val;
  assign count_en   = enable && (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q & ~clear_flags;
    unf_d   = unf_q & ~clear_flags;
    if (load) begin
      q_d     = load_clamp;
      state_d = ST_RUN;
    end else begin
      if ((state_q == ST_DONE) && (mode != MODE_ONESHOT)) begin
        state_d = ST_RUN;
      end
      if (count_en) begin
        q_d  = nxt_q;
        tc_d = ovf_cross | unf_cross;
        // A crossing on the same edge as clear_flags leaves its flag set.
        if (ovf_cross) ovf_d = 1'b1;
        if (unf_cross) unf_d = 1'b1;
        if ((ovf_cross || unf_cross) && (mode == MODE_ONESHOT)) begin
          state_d = ST_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
      q_q     <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign q    = q_q;
  assign tc   = tc_q;
  assign ovf  = ovf_q;
  assign unf  = unf_q;
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_mod_counter.sv
// Directed vector bench for mod_counter (WIDTH=8, STEP_W=4).
module tb_mod_counter;

  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;

  logic              clk;
  logic              reset;
  logic              enable;
  logic              up_down;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  max_val;
  logic [1:0]        mode;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              clear_flags;
  logic [WIDTH-1:0]  q;
  logic              tc;
  logic              ovf;
  logic              unf;
  logic              done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic       ud;
    logic [3:0] stp;
    logic [7:0] maxv;
    logic [1:0] md;
    logic       ld;
    logic [7:0] ldv;
    logic       clr;
    logic [7:0] eq;
    logic       etc;
    logic       eovf;
    logic       eunf;
    logic       edone;
  } vec_t;

  vec_t tbl[$];

  mod_counter #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .up_down     (up_down),
    .step        (step),
    .max_val     (max_val),
    .mode        (mode),
    .load        (load),
    .load_val    (load_val),
    .clear_flags (clear_flags),
    .q           (q),
    .tc          (tc),
    .ovf         (ovf),
    .unf         (unf),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic rst, logic en, logic ud, logic [3:0] stp, logic [7:0] maxv,
                              logic [1:0] md, logic ld, logic [7:0] ldv, logic clr,
                              logic [7:0] eq, logic etc, logic eovf, logic eunf, logic edone);
    vec_t v;
    v.rst = rst; v.en = en; v.ud = ud; v.stp = stp; v.maxv = maxv; v.md = md;
    v.ld = ld; v.ldv = ldv; v.clr = clr;
    v.eq = eq; v.etc = etc; v.eovf = eovf; v.eunf = eunf; v.edone = edone;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    reset = v.rst; enable = v.en; up_down = v.ud; step = v.stp; max_val = v.maxv;
    mode = v.md; load = v.ld; load_val = v.ldv; clear_flags = v.clr;
    @(posedge clk);
    #1;
    chk("q",    idx, q,           v.eq);
    chk("tc",   idx, {7'd0, tc},   {7'd0, v.etc});
    chk("ovf",  idx, {7'd0, ovf},  {7'd0, v.eovf});
    chk("unf",  idx, {7'd0, unf},  {7'd0, v.eunf});
    chk("done", idx, {7'd0, done}, {7'd0, v.edone});
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; up_down = 1'b0; step = '0; max_val = '0;
    mode = 2'd0; load = 1'b0; load_val = '0; clear_flags = 1'b0;

    //                rst en ud stp maxv md ld ldv clr   q  tc ov un dn
    // reset beats load, then first count
    tbl.push_back(mk(0, 1, 1, 1, 255, 0, 1,   5, 0,    0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 255, 0, 0,   0, 0,    1, 0, 0, 0, 0));
    // wrap up
    tbl.push_back(mk(1, 0, 1, 3,   9, 0, 1,   8, 0,    8, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 3,   9, 0, 0,   0, 0,    1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 3,   9, 0, 0,   0, 0,    1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 3,   9, 0, 0,   0, 1,    1, 0, 0, 0, 0));
    // saturate down
    tbl.push_back(mk(1, 0, 0, 5, 200, 1, 1,   2, 0,    2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 5, 200, 1, 0,   0, 0,    0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 5, 200, 1, 0,   0, 0,    0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 5, 200, 1, 0,   0, 0,    0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 5, 200, 1, 0,   0, 1,    0, 0, 0, 0, 0));
    // oneshot
    tbl.push_back(mk(1, 0, 1, 4,  15, 2, 1,  14, 0,   14, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 4,  15, 2, 0,   0, 0,   15, 1, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 4,  15, 2, 0,   0, 0,   15, 0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 4,  15, 2, 0,   0, 0,   15, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 1, 4,  15, 2, 1,   3, 0,    3, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 4,  15, 2, 0,   0, 1,    3, 0, 0, 0, 0));
    // priority and limits
    tbl.push_back(mk(1, 1, 1, 1, 100, 0, 1, 250, 0,  100, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1,  50, 0, 0,   0, 0,   50, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1,  50, 0, 0,   0, 0,    0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1,  50, 0, 0,   0, 1,    1, 0, 0, 0, 0));
    // clear_flags racing an overflow: set wins
    tbl.push_back(mk(1, 0, 1, 3,  50, 0, 1,  49, 0,   49, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 3,  50, 0, 0,   0, 1,    1, 1, 1, 0, 0));
    // step clamped to max_val, zero step, down wrap, reserved mode
    tbl.push_back(mk(1, 0, 1, 15,  2, 0, 1,   1, 0,    1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 15,  2, 0, 0,   0, 0,    0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0,   2, 0, 0,   0, 0,    0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 1,   2, 0, 0,   0, 0,    2, 1, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1, 1,   2, 3, 0,   0, 0,    0, 1, 1, 1, 0));
    // reset while in DONE, then resume
    tbl.push_back(mk(1, 0, 1, 4,  15, 2, 1,  14, 0,   14, 0, 1, 1, 0));
    tbl.push_back(mk(1, 1, 1, 4,  15, 2, 0,   0, 0,   15, 1, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 4,  15, 2, 0,   0, 0,    0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1,  15, 2, 0,   0, 0,    1, 0, 0, 0, 0));
    // leaving DONE by a mode change
    tbl.push_back(mk(1, 0, 1, 1,  15, 2, 1,  15, 0,   15, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1,  15, 2, 0,   0, 0,   15, 1, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 1,  15, 0, 0,   0, 0,   15, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1,  15, 0, 0,   0, 0,    0, 1, 1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end

    // Saturate up through the ceiling over several cycles, then clear.
    apply(mk(1, 0, 1, 3, 255, 1, 1, 250, 0,  250, 0, 1, 0, 0), 100);
    apply(mk(1, 1, 1, 3, 255, 1, 0,   0, 0,  253, 0, 1, 0, 0), 101);
    apply(mk(1, 1, 1, 3, 255, 1, 0,   0, 0,  255, 1, 1, 0, 0), 102);
    apply(mk(1, 1, 1, 3, 255, 1, 0,   0, 0,  255, 1, 1, 0, 0), 103);
    apply(mk(1, 0, 1, 3, 255, 1, 0,   0, 1,  255, 0, 0, 0, 0), 104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
